// File: rtl/coincidence_edge_finder_if.sv
// ---------------------------------------------------------------------------
// coincidence_edge_finder_if
//
// Groups the control/status handshake of the alignment sequencer and its CSR
// bus towards the coincidence recorder.
//
//   sysStart      one-cycle start request (into the sequencer)
//   sysChannel    channel to scan, sampled with an accepted start
//   sysBusy       sequence in progress
//   sysDone       one-cycle pulse at the end of a sequence
//   sysEdgeFound  last sequence found an edge
//   sysEdgeIndex  edge bin of the last successful sequence
//   sysTimeout    last sequence timed out
//   recCsrStrobe  CSR write strobe to the recorder
//   recGPIO_OUT   CSR write data, valid with recCsrStrobe
//   recCsr        recorder readback word
//
// The master modport is the sequencer; the slave modport is the side that
// issues starts and models/hosts the recorder.
// ---------------------------------------------------------------------------
interface coincidence_edge_finder_if #(
    parameter int CHANNEL_COUNT               = 2,
    parameter int SAMPLE_CLKS_PER_COINCIDENCE = 80
);
    localparam int MUXSEL_WIDTH         = $clog2(CHANNEL_COUNT);
    localparam int SAMPLE_COUNTER_WIDTH = $clog2(SAMPLE_CLKS_PER_COINCIDENCE);

    logic                            sysStart;
    logic [MUXSEL_WIDTH-1:0]         sysChannel;
    logic                            sysBusy;
    logic                            sysDone;
    logic                            sysEdgeFound;
    logic [SAMPLE_COUNTER_WIDTH-1:0] sysEdgeIndex;
    logic                            sysTimeout;
    logic                            recCsrStrobe;
    logic [31:0]                     recGPIO_OUT;
    logic [31:0]                     recCsr;

    modport master (
        input  sysStart,
        input  sysChannel,
        input  recCsr,
        output sysBusy,
        output sysDone,
        output sysEdgeFound,
        output sysEdgeIndex,
        output sysTimeout,
        output recCsrStrobe,
        output recGPIO_OUT
    );

    modport slave (
        output sysStart,
        output sysChannel,
        output recCsr,
        input  sysBusy,
        input  sysDone,
        input  sysEdgeFound,
        input  sysEdgeIndex,
        input  sysTimeout,
        input  recCsrStrobe,
        input  recGPIO_OUT
    );
endinterface

// File: rtl/coincidence_edge_finder.sv
// ---------------------------------------------------------------------------
// coincidence_edge_finder
//
// Automatic alignment sequencer for the coincidence recorder. On a start it
// arms an acquisition, waits for the recorder to run it, scans one channel's
// histogram bin by bin, locates the first rising crossing of half the
// acquisition length, programs the coincidence sample count (edge plus a
// fixed offset, modulo the histogram length) and requests a heartbeat
// realign.
//
// Ports:
//   sysClk      system clock
//   sysReset_n  asynchronous active-low reset; aborts a running sequence
//   bus         coincidence_edge_finder_if master modport (start/status and
//               recorder CSR strobe, write data and readback)
// ---------------------------------------------------------------------------
module coincidence_edge_finder #(
    parameter int CHANNEL_COUNT               = 2,
    parameter int CYCLES_PER_ACQUISITION      = 1023,
    parameter int SAMPLE_CLKS_PER_COINCIDENCE = 80,
    parameter int EDGE_OFFSET                 = 0,
    parameter int TIMEOUT_CYCLES              = 1 << 20
) (
    input  logic                       sysClk,
    input  logic                       sysReset_n,
    coincidence_edge_finder_if.master  bus
);
    localparam int MUXSEL_WIDTH         = $clog2(CHANNEL_COUNT);
    localparam int SUM_WIDTH            = $clog2(CYCLES_PER_ACQUISITION + 1);
    localparam int SAMPLE_COUNTER_WIDTH = $clog2(SAMPLE_CLKS_PER_COINCIDENCE);
    localparam int ADDR_WIDTH           = SAMPLE_COUNTER_WIDTH + 1;
    localparam int TIMEOUT_WIDTH        = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SUM_WIDTH-1:0]     THRESHOLD    = SUM_WIDTH'((CYCLES_PER_ACQUISITION + 1) / 2);
    localparam logic [ADDR_WIDTH-1:0]    N_EXT        = ADDR_WIDTH'(SAMPLE_CLKS_PER_COINCIDENCE);
    localparam logic [ADDR_WIDTH-1:0]    OFFSET_EXT   = ADDR_WIDTH'(EDGE_OFFSET);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    localparam logic [31:0] CMD_ARM     = 32'h8000_0000;
    localparam logic [31:0] CMD_REALIGN = 32'h2000_0000;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ARM       = 4'd1;
    localparam logic [3:0] S_WAIT_BUSY = 4'd2;
    localparam logic [3:0] S_WAIT_IDLE = 4'd3;
    localparam logic [3:0] S_REQ       = 4'd4;
    localparam logic [3:0] S_WAIT_RB   = 4'd5;
    localparam logic [3:0] S_EVAL      = 4'd6;
    localparam logic [3:0] S_SET       = 4'd7;
    localparam logic [3:0] S_REALIGN   = 4'd8;
    localparam logic [3:0] S_FINISH    = 4'd9;

    logic [3:0]                      state_q,     state_d;
    logic [MUXSEL_WIDTH-1:0]         channel_q,   channel_d;
    logic [ADDR_WIDTH-1:0]           scanAddr_q,  scanAddr_d;
    logic                            prevAbove_q, prevAbove_d;
    logic                            above_q,     above_d;
    logic                            matchSeen_q, matchSeen_d;
    logic [TIMEOUT_WIDTH-1:0]        waitCnt_q,   waitCnt_d;
    logic [SAMPLE_COUNTER_WIDTH-1:0] edge_q,      edge_d;
    logic                            strobe_q,    strobe_d;
    logic [31:0]                     gpio_q,      gpio_d;
    logic                            busy_q,      busy_d;
    logic                            done_q,      done_d;
    logic                            found_q,     found_d;
    logic [SAMPLE_COUNTER_WIDTH-1:0] edgeIndex_q, edgeIndex_d;
    logic                            timeout_q,   timeout_d;

    logic                            rbBusy;
    logic [MUXSEL_WIDTH-1:0]         rbMux;
    logic [SAMPLE_COUNTER_WIDTH-1:0] rbAddr;
    logic [SUM_WIDTH-1:0]            rbSum;
    logic                            unusedCsrParity;

    logic [SAMPLE_COUNTER_WIDTH-1:0] reqAddr;
    logic                            rbMatch;
    logic                            waitExpired;
    logic [ADDR_WIDTH-1:0]           targetSum;
    logic [ADDR_WIDTH-1:0]           targetWrapped;
    logic [SAMPLE_COUNTER_WIDTH-1:0] targetBin;
    logic [31:0]                     reqWord;
    logic [31:0]                     setWord;

    // Readback fields. The recorder forwarding path is quasi-static, so it
    // is used directly; the two-cycle match rule absorbs transition skew.
    assign rbBusy          = bus.recCsr[31];
    assign rbMux           = bus.recCsr[24 +: MUXSEL_WIDTH];
    assign rbAddr          = bus.recCsr[SUM_WIDTH +: SAMPLE_COUNTER_WIDTH];
    assign rbSum           = bus.recCsr[0 +: SUM_WIDTH];
    assign unusedCsrParity = ^bus.recCsr;

    // Address N re-reads bin 0 so an edge sitting on the wrap is caught.
    assign reqAddr     = (scanAddr_q == N_EXT) ? '0 : scanAddr_q[SAMPLE_COUNTER_WIDTH-1:0];
    assign rbMatch     = (rbMux == channel_q) && (rbAddr == reqAddr);
    assign waitExpired = (waitCnt_q == TIMEOUT_LAST);

    // Target = (edge + offset) mod N; both terms are below N so a single
    // conditional subtract is enough.
    assign targetSum     = {1'b0, edge_q} + OFFSET_EXT;
    assign targetWrapped = targetSum - N_EXT;
    assign targetBin     = (targetSum >= N_EXT) ? targetWrapped[SAMPLE_COUNTER_WIDTH-1:0]
                                                : targetSum[SAMPLE_COUNTER_WIDTH-1:0];

    // Bin read request: channel in the mux field, bin in the low bits.
    always_comb begin
        reqWord                           = '0;
        reqWord[24 +: MUXSEL_WIDTH]       = channel_q;
        reqWord[0 +: SAMPLE_COUNTER_WIDTH] = reqAddr;
    end

    // Coincidence sample count write.
    always_comb begin
        setWord                            = '0;
        setWord[30]                        = 1'b1;
        setWord[0 +: SAMPLE_COUNTER_WIDTH] = targetBin;
    end

    // Sequencer next-state logic. Strobes are produced as next-state values
    // so the CSR strobe leaves the block registered.
    always_comb begin
        state_d     = state_q;
        channel_d   = channel_q;
        scanAddr_d  = scanAddr_q;
        prevAbove_d = prevAbove_q;
        above_d     = above_q;
        matchSeen_d = matchSeen_q;
        waitCnt_d   = waitCnt_q;
        edge_d      = edge_q;
        strobe_d    = 1'b0;
        gpio_d      = gpio_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        found_d     = found_q;
        edgeIndex_d = edgeIndex_q;
        timeout_d   = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (bus.sysStart) begin
                    channel_d = bus.sysChannel;
                    found_d   = 1'b0;
                    timeout_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_ARM;
                end
            end

            S_ARM: begin
                strobe_d  = 1'b1;
                gpio_d    = CMD_ARM;
                waitCnt_d = '0;
                state_d   = S_WAIT_BUSY;
            end

            S_WAIT_BUSY: begin
                if (rbBusy) begin
                    waitCnt_d = '0;
                    state_d   = S_WAIT_IDLE;
                end else if (waitExpired) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end

            S_WAIT_IDLE: begin
                if (!rbBusy) begin
                    scanAddr_d  = '0;
                    prevAbove_d = 1'b0;
                    state_d     = S_REQ;
                end else if (waitExpired) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end

            S_REQ: begin
                strobe_d    = 1'b1;
                gpio_d      = reqWord;
                waitCnt_d   = '0;
                matchSeen_d = 1'b0;
                state_d     = S_WAIT_RB;
            end

            // The readback must match on two consecutive cycles before its
            // sum is trusted, so stale forwarded data is never evaluated.
            S_WAIT_RB: begin
                if (rbMatch && matchSeen_q) begin
                    above_d = (rbSum >= THRESHOLD);
                    state_d = S_EVAL;
                end else if (waitExpired) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    matchSeen_d = rbMatch;
                    waitCnt_d   = waitCnt_q + 1'b1;
                end
            end

            S_EVAL: begin
                if ((scanAddr_q != '0) && !prevAbove_q && above_q) begin
                    edge_d  = reqAddr;
                    state_d = S_SET;
                end else if (scanAddr_q == N_EXT) begin
                    state_d = S_FINISH;
                end else begin
                    prevAbove_d = above_q;
                    scanAddr_d  = scanAddr_q + 1'b1;
                    state_d     = S_REQ;
                end
            end

            S_SET: begin
                strobe_d    = 1'b1;
                gpio_d      = setWord;
                edgeIndex_d = edge_q;
                found_d     = 1'b1;
                state_d     = S_REALIGN;
            end

            // Hold off one cycle after the SET strobe so strobes are never
            // back to back.
            S_REALIGN: begin
                if (!strobe_q) begin
                    strobe_d = 1'b1;
                    gpio_d   = CMD_REALIGN;
                    state_d  = S_FINISH;
                end
            end

            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any sequence in flight.
    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            state_q     <= S_IDLE;
            channel_q   <= '0;
            scanAddr_q  <= '0;
            prevAbove_q <= 1'b0;
            above_q     <= 1'b0;
            matchSeen_q <= 1'b0;
            waitCnt_q   <= '0;
            edge_q      <= '0;
            strobe_q    <= 1'b0;
            gpio_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            edgeIndex_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            channel_q   <= channel_d;
            scanAddr_q  <= scanAddr_d;
            prevAbove_q <= prevAbove_d;
            above_q     <= above_d;
            matchSeen_q <= matchSeen_d;
            waitCnt_q   <= waitCnt_d;
            edge_q      <= edge_d;
            strobe_q    <= strobe_d;
            gpio_q      <= gpio_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            found_q     <= found_d;
            edgeIndex_q <= edgeIndex_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.recCsrStrobe = strobe_q;
    assign bus.recGPIO_OUT  = gpio_q;
    assign bus.sysBusy      = busy_q;
    assign bus.sysDone      = done_q;
    assign bus.sysEdgeFound = found_q;
    assign bus.sysEdgeIndex = edgeIndex_q;
    assign bus.sysTimeout   = timeout_q;
endmodule

// File: tb/tb_coincidence_edge_finder.sv
// ---------------------------------------------------------------------------
// tb_coincidence_edge_finder
//
// Drives the alignment sequencer against a behavioural recorder: arm makes
// the recorder busy for a while, bin reads come back after a fixed delay
// (optionally preceded by a wrong address), and every CSR write is logged.
// Expected writes and results are derived from the histogram by a plain scan.
// ---------------------------------------------------------------------------
module tb_coincidence_edge_finder;
    localparam int N            = 80;
    localparam int CYCLES       = 1023;
    localparam int THRESH       = (CYCLES + 1) / 2;
    localparam int OFFSET       = 4;
    localparam int TMO          = 1000;
    localparam int RB_DELAY     = 5;
    localparam int STALE_CYCLES = 3;
    localparam int BUSY_CYCLES  = 10;
    localparam int DONE_LIMIT   = 4000;

    logic sysClk;
    logic sysReset_n;
    int   compared   = 0;
    int   mismatched = 0;
    int   cycleNo    = 0;
    int   startCycle = 0;

    coincidence_edge_finder_if #(
        .CHANNEL_COUNT(2),
        .SAMPLE_CLKS_PER_COINCIDENCE(N)
    ) bus ();

    coincidence_edge_finder #(
        .CHANNEL_COUNT(2),
        .CYCLES_PER_ACQUISITION(CYCLES),
        .SAMPLE_CLKS_PER_COINCIDENCE(N),
        .EDGE_OFFSET(OFFSET),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .sysClk(sysClk),
        .sysReset_n(sysReset_n),
        .bus(bus)
    );

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    always @(posedge sysClk) cycleNo <= cycleNo + 1;

    // Recorder model state
    int          hist [2][N];
    logic        neverBusy  = 1'b0;
    logic        staleMode  = 1'b0;
    logic        clearLog   = 1'b0;
    logic [31:0] writes [$];
    int          backToBack = 0;
    int          armCycle   = 0;
    logic        prevStrobe = 1'b0;
    logic        recBusy    = 1'b0;
    int          armDelay   = 0;
    int          busyLeft   = 0;
    int          rbDelay    = 0;
    int          staleLeft  = 0;
    logic        reqMux     = 1'b0;
    logic        shownMux   = 1'b0;
    int          reqAddr    = 0;
    int          shownAddr  = 0;

    // Expected results
    logic [31:0] expWrites [$];
    logic        expFound;
    int          expEdge;

    // Behavioural recorder, evaluated on the falling edge
    always @(negedge sysClk) begin
        if (clearLog) begin
            writes.delete();
            backToBack = 0;
        end
        if (bus.recCsrStrobe === 1'b1) begin
            writes.push_back(bus.recGPIO_OUT);
            if (prevStrobe) backToBack++;
            if (bus.recGPIO_OUT == 32'h8000_0000) begin
                armCycle = cycleNo;
                if (!neverBusy) armDelay = 3;
            end else if (bus.recGPIO_OUT[31:29] == 3'b000) begin
                reqMux  = bus.recGPIO_OUT[24];
                reqAddr = int'(bus.recGPIO_OUT[6:0]);
                rbDelay = RB_DELAY;
            end
        end
        prevStrobe = (bus.recCsrStrobe === 1'b1);
        if (armDelay > 0) begin
            armDelay--;
            if (armDelay == 0) begin
                recBusy  = 1'b1;
                busyLeft = BUSY_CYCLES;
            end
        end else if (busyLeft > 0) begin
            busyLeft--;
            if (busyLeft == 0) recBusy = 1'b0;
        end
        if (rbDelay > 0) begin
            rbDelay--;
            if (rbDelay == 0) begin
                shownMux = reqMux;
                if (staleMode) begin
                    shownAddr = (reqAddr + 1) % N;
                    staleLeft = STALE_CYCLES;
                end else begin
                    shownAddr = reqAddr;
                end
            end
        end else if (staleLeft > 0) begin
            staleLeft--;
            if (staleLeft == 0) shownAddr = reqAddr;
        end
        bus.recCsr = {recBusy, 6'b0, shownMux, 7'b0, 7'(shownAddr), 10'(hist[shownMux][shownAddr])};
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic fillRange(input int ch, input int lo, input int hi, input logic high);
        for (int b = lo; b <= hi; b++)
            hist[ch][b] = high ? int'($urandom_range(CYCLES, THRESH)) : int'($urandom_range(THRESH - 1, 0));
    endtask

    task automatic fillRandom(input int ch);
        for (int b = 0; b < N; b++) hist[ch][b] = int'($urandom_range(CYCLES, 0));
    endtask

    // Scan bins 0..N in order; the first below-to-above step wins.
    task automatic buildExpected(input int ch);
        expWrites.delete();
        expWrites.push_back(32'h8000_0000);
        expFound = 1'b0;
        expEdge  = 0;
        for (int a = 0; a <= N; a++) begin
            expWrites.push_back((32'(ch) << 24) | 32'(a % N));
            if (a >= 1 && hist[ch][(a - 1) % N] < THRESH && hist[ch][a % N] >= THRESH) begin
                expFound = 1'b1;
                expEdge  = a % N;
                break;
            end
        end
        if (expFound) begin
            expWrites.push_back(32'h4000_0000 | 32'((expEdge + OFFSET) % N));
            expWrites.push_back(32'h2000_0000);
        end
    endtask

    task automatic clearModelLog();
        @(posedge sysClk);
        clearLog = 1'b1;
        @(posedge sysClk);
        clearLog = 1'b0;
    endtask

    task automatic applyStimulus(input int ch);
        @(negedge sysClk);
        bus.sysChannel = 1'(ch);
        bus.sysStart   = 1'b1;
        startCycle     = cycleNo;
        @(negedge sysClk);
        bus.sysStart = 1'b0;
    endtask

    task automatic waitDone(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < DONE_LIMIT && !seen; i++) begin
            @(negedge sysClk);
            if (bus.sysDone === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic checkSequence(input string tag, input int ch);
        logic seen;
        buildExpected(ch);
        waitDone(seen);
        checkOutput({tag, ".done"}, 32'(seen), 32'd1);
        if (seen) begin
            checkOutput({tag, ".busy"}, 32'(bus.sysBusy), 32'd0);
            checkOutput({tag, ".found"}, 32'(bus.sysEdgeFound), 32'(expFound));
            checkOutput({tag, ".timeout"}, 32'(bus.sysTimeout), 32'd0);
            if (expFound) checkOutput({tag, ".edgeIndex"}, 32'(bus.sysEdgeIndex), 32'(expEdge));
            @(negedge sysClk);
            checkOutput({tag, ".donePulse"}, 32'(bus.sysDone), 32'd0);
        end
        checkOutput({tag, ".writeCount"}, 32'(writes.size()), 32'(expWrites.size()));
        for (int i = 0; i < expWrites.size() && i < writes.size(); i++) begin
            checkOutput($sformatf("%s.write%0d", tag, i), writes[i], expWrites[i]);
            if (writes[i] !== expWrites[i]) break;
        end
        checkOutput({tag, ".backToBack"}, 32'(backToBack), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".busy"}, 32'(bus.sysBusy), 32'd0);
        checkOutput({tag, ".done"}, 32'(bus.sysDone), 32'd0);
        checkOutput({tag, ".found"}, 32'(bus.sysEdgeFound), 32'd0);
        checkOutput({tag, ".edgeIndex"}, 32'(bus.sysEdgeIndex), 32'd0);
        checkOutput({tag, ".timeout"}, 32'(bus.sysTimeout), 32'd0);
        checkOutput({tag, ".strobe"}, 32'(bus.recCsrStrobe), 32'd0);
        checkOutput({tag, ".gpio"}, bus.recGPIO_OUT, 32'd0);
    endtask

    function automatic logic [31:0] setWriteOf();
        if (writes.size() >= 2) return writes[writes.size() - 2];
        return 32'hFFFF_FFFF;
    endfunction

    // Watchdog so the run always ends
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic seen;
        logic reached;
        int   elapsed;

        bus.sysStart   = 1'b0;
        bus.sysChannel = 1'b0;
        sysReset_n     = 1'b0;
        for (int c = 0; c < 2; c++) fillRange(c, 0, N - 1, 1'b0);
        repeat (3) @(negedge sysClk);
        checkAllZero("reset");
        sysReset_n = 1'b1;

        // Edge at bin 37 on channel 1, with a start pulse mid-sequence
        fillRange(1, 0, 36, 1'b0);
        fillRange(1, 37, N - 1, 1'b1);
        fillRange(0, 0, 36, 1'b1);
        fillRange(0, 37, N - 1, 1'b0);
        clearModelLog();
        applyStimulus(1);
        repeat (30) @(negedge sysClk);
        bus.sysChannel = 1'b0;
        bus.sysStart   = 1'b1;
        @(negedge sysClk);
        bus.sysStart = 1'b0;
        checkSequence("edge37", 1);
        checkOutput("edge37.armLatency", 32'(armCycle - startCycle), 32'd2);
        checkOutput("edge37.setWord", setWriteOf(), 32'h4000_0029);

        // Edge at bin 0 found only across the wrap
        fillRange(0, 0, 9, 1'b1);
        fillRange(0, 10, N - 1, 1'b0);
        clearModelLog();
        applyStimulus(0);
        checkSequence("edgeWrap", 0);
        checkOutput("edgeWrap.setWord", setWriteOf(), 32'h4000_0004);

        // Edge at bin 78, target wraps to 2
        fillRange(1, 0, 77, 1'b0);
        fillRange(1, 78, N - 1, 1'b1);
        clearModelLog();
        applyStimulus(1);
        checkSequence("edge78", 1);
        checkOutput("edge78.setWord", setWriteOf(), 32'h4000_0002);

        // Constant histogram: no edge, no SET/REALIGN writes
        for (int b = 0; b < N; b++) hist[0][b] = CYCLES;
        clearModelLog();
        applyStimulus(0);
        checkSequence("flat", 0);

        // Recorder never goes busy: timeout after the arm write only
        neverBusy = 1'b1;
        clearModelLog();
        applyStimulus(1);
        waitDone(seen);
        checkOutput("timeout.done", 32'(seen), 32'd1);
        checkOutput("timeout.flag", 32'(bus.sysTimeout), 32'd1);
        checkOutput("timeout.found", 32'(bus.sysEdgeFound), 32'd0);
        checkOutput("timeout.writeCount", 32'(writes.size()), 32'd1);
        checkOutput("timeout.armWrite", (writes.size() > 0) ? writes[0] : 32'hFFFF_FFFF, 32'h8000_0000);
        elapsed = cycleNo - armCycle;
        checkOutput("timeout.latencyInWindow", 32'(elapsed >= TMO && elapsed <= TMO + 3), 32'd1);
        neverBusy = 1'b0;
        repeat (3) @(negedge sysClk);

        // Wrong address shown before the real readback
        staleMode = 1'b1;
        fillRange(1, 0, 36, 1'b0);
        fillRange(1, 37, N - 1, 1'b1);
        clearModelLog();
        applyStimulus(1);
        checkSequence("stale", 1);
        checkOutput("stale.setWord", setWriteOf(), 32'h4000_0029);
        staleMode = 1'b0;

        // Reset while reading bin 20, then a clean restart
        clearModelLog();
        applyStimulus(1);
        reached = 1'b0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            @(negedge sysClk);
            if (writes.size() > 0 && writes[writes.size() - 1] == 32'h0100_0014) reached = 1'b1;
        end
        checkOutput("reset.reachBin20", 32'(reached), 32'd1);
        sysReset_n = 1'b0;
        #1;
        checkAllZero("midReset");
        clearModelLog();
        repeat (5) @(negedge sysClk);
        checkOutput("midReset.noStrobes", 32'(writes.size()), 32'd0);
        sysReset_n = 1'b1;
        applyStimulus(1);
        checkSequence("restart", 1);

        // Randomised histograms
        for (int t = 0; t < 8; t++) begin
            int ch;
            int kind;
            int e;
            ch   = int'($urandom_range(1, 0));
            kind = int'($urandom_range(2, 0));
            e    = int'($urandom_range(N - 1, 1));
            fillRandom(1 - ch);
            if (kind == 0) begin
                fillRange(ch, 0, e - 1, 1'b0);
                fillRange(ch, e, N - 1, 1'b1);
            end else if (kind == 1) begin
                fillRange(ch, 0, e - 1, 1'b1);
                fillRange(ch, e, N - 1, 1'b0);
            end else begin
                fillRandom(ch);
            end
            clearModelLog();
            applyStimulus(ch);
            checkSequence($sformatf("rand%0d", t), ch);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
